// File: rtl/iir_sos_ctrl_if.sv
// iir_sos_ctrl_if
// Bundles the coefficient-load bus, the sample handshake and the per-section
// control lines that connect iir_sos_ctrl to its environment.
//   cfg_start/cfg_busy/cfg_loaded : coefficient (re)load request and status
//   rom_addr/rom_data             : synchronous coefficient ROM port
//   c_we/c_addr/c_in              : coefficient write bus to the sections
//   samp_stb/samp_acc             : new-sample strobe and acceptance pulse
//   ce/mult_sel                   : per-section clock enables, shared mult select
//   out_valid/run_busy            : cascade output strobe, sequence in progress
//   ovr_cnt                       : overrun counter
// Modports: master = the sequencer, slave = the surrounding logic.
interface iir_sos_ctrl_if #(
    parameter int N_SECT  = 4,
    parameter int SECT_AW = 2,
    parameter int COEFF_W = 16
) ();
    logic                 cfg_start;
    logic                 cfg_busy;
    logic                 cfg_loaded;
    logic [SECT_AW+1:0]   rom_addr;
    logic [COEFF_W-1:0]   rom_data;
    logic [N_SECT-1:0]    c_we;
    logic [1:0]           c_addr;
    logic [COEFF_W-1:0]   c_in;
    logic                 samp_stb;
    logic                 samp_acc;
    logic [N_SECT-1:0]    ce;
    logic                 mult_sel;
    logic                 out_valid;
    logic                 run_busy;
    logic [15:0]          ovr_cnt;

    modport master (
        input  cfg_start, rom_data, samp_stb,
        output cfg_busy, cfg_loaded, rom_addr, c_we, c_addr, c_in,
               samp_acc, ce, mult_sel, out_valid, run_busy, ovr_cnt
    );

    modport slave (
        output cfg_start, rom_data, samp_stb,
        input  cfg_busy, cfg_loaded, rom_addr, c_we, c_addr, c_in,
               samp_acc, ce, mult_sel, out_valid, run_busy, ovr_cnt
    );
endinterface

// File: rtl/iir_sos_ctrl.sv
// iir_sos_ctrl
// Sequencer for a cascade of N_SECT iir_sos biquad sections. On cfg_start it
// streams 3*N_SECT coefficient words from a synchronous ROM into the sections
// (read of word j+1 overlaps the write of word j). On each accepted samp_stb it
// walks sections 0..N_SECT-1 through M0 (ce, mult_sel=0), M1 (ce, mult_sel=1)
// and GAP (no ce), then pulses out_valid.
// Ports:
//   clk  : single clock
//   nrst : synchronous active-low reset
//   bus  : iir_sos_ctrl_if.master (coefficient bus, sample handshake, controls)
// Optional feature: define IIR_SOS_CTRL_OVR_CNT_EN to count overrun strobes in
// ovr_cnt (saturating); otherwise ovr_cnt is tied to zero.
module iir_sos_ctrl #(
    parameter int N_SECT  = 4,
    parameter int SECT_AW = 2,
    parameter int COEFF_W = 16
) (
    input  logic                clk,
    input  logic                nrst,
    iir_sos_ctrl_if.master      bus
);
    localparam int                 AW        = SECT_AW + 2;
    localparam logic [SECT_AW-1:0] LAST_SEC  = SECT_AW'(N_SECT - 1);
    localparam logic [AW-1:0]      LAST_ADDR = {LAST_SEC, 2'd2};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG     = 3'd1,
        S_RUN_M0  = 3'd2,
        S_RUN_M1  = 3'd3,
        S_RUN_GAP = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [SECT_AW-1:0]  sec_q, sec_d;
    logic                cfg_last_q, cfg_last_d;
    logic                cfg_loaded_q, cfg_loaded_d;
    logic                cfg_busy_q, cfg_busy_d;
    logic [AW-1:0]       rom_addr_q, rom_addr_d;
    logic [N_SECT-1:0]   c_we_q, c_we_d;
    logic [1:0]          c_addr_q, c_addr_d;
    logic                wr_q, wr_d;
    logic                samp_acc_q, samp_acc_d;
    logic [N_SECT-1:0]   ce_q, ce_d;
    logic                mult_sel_q, mult_sel_d;
    logic                out_valid_q, out_valid_d;
    logic                run_busy_q, run_busy_d;

    function automatic logic [N_SECT-1:0] sect_onehot(input logic [SECT_AW-1:0] s);
        logic [N_SECT-1:0] r;
        for (int k = 0; k < N_SECT; k++) begin
            r[k] = (s == SECT_AW'(k));
        end
        return r;
    endfunction

    // Next-state and next-output logic; outputs are computed for the coming cycle.
    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        cfg_last_d   = cfg_last_q;
        cfg_loaded_d = cfg_loaded_q;
        cfg_busy_d   = 1'b0;
        rom_addr_d   = {AW{1'b0}};
        c_we_d       = {N_SECT{1'b0}};
        c_addr_d     = 2'd0;
        wr_d         = 1'b0;
        samp_acc_d   = 1'b0;
        ce_d         = {N_SECT{1'b0}};
        mult_sel_d   = 1'b0;
        out_valid_d  = 1'b0;
        run_busy_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    // rom_addr_d stays at word 0, which is the first read.
                    state_d    = S_CFG;
                    cfg_busy_d = 1'b1;
                    cfg_last_d = 1'b0;
                end else if (bus.samp_stb && cfg_loaded_q) begin
                    state_d    = S_RUN_M0;
                    sec_d      = {SECT_AW{1'b0}};
                    samp_acc_d = 1'b1;
                    ce_d       = sect_onehot({SECT_AW{1'b0}});
                    run_busy_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CFG: begin
                if (cfg_last_q) begin
                    // Final write is on the bus this cycle; no read left.
                    state_d      = S_IDLE;
                    cfg_loaded_d = 1'b1;
                    cfg_last_d   = 1'b0;
                end else begin
                    // Word addressed now has its data next cycle: write it then.
                    cfg_busy_d = 1'b1;
                    wr_d       = 1'b1;
                    c_we_d     = sect_onehot(rom_addr_q[AW-1:2]);
                    c_addr_d   = rom_addr_q[1:0];
                    if (rom_addr_q == LAST_ADDR) begin
                        cfg_last_d = 1'b1;
                        rom_addr_d = {AW{1'b0}};
                    end else if (rom_addr_q[1:0] == 2'd2) begin
                        // Skip the unused index 3 and move to the next section.
                        rom_addr_d = rom_addr_q + AW'(2);
                    end else begin
                        rom_addr_d = rom_addr_q + AW'(1);
                    end
                end
            end
            S_RUN_M0: begin
                state_d    = S_RUN_M1;
                ce_d       = sect_onehot(sec_q);
                mult_sel_d = 1'b1;
                run_busy_d = 1'b1;
            end
            S_RUN_M1: begin
                state_d    = S_RUN_GAP;
                run_busy_d = 1'b1;
            end
            S_RUN_GAP: begin
                if (sec_q == LAST_SEC) begin
                    state_d     = S_IDLE;
                    sec_d       = {SECT_AW{1'b0}};
                    out_valid_d = 1'b1;
                end else begin
                    state_d    = S_RUN_M0;
                    sec_d      = sec_q + SECT_AW'(1);
                    ce_d       = sect_onehot(sec_q + SECT_AW'(1));
                    run_busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            sec_q        <= {SECT_AW{1'b0}};
            cfg_last_q   <= 1'b0;
            cfg_loaded_q <= 1'b0;
            cfg_busy_q   <= 1'b0;
            rom_addr_q   <= {AW{1'b0}};
            c_we_q       <= {N_SECT{1'b0}};
            c_addr_q     <= 2'd0;
            wr_q         <= 1'b0;
            samp_acc_q   <= 1'b0;
            ce_q         <= {N_SECT{1'b0}};
            mult_sel_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            run_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            cfg_last_q   <= cfg_last_d;
            cfg_loaded_q <= cfg_loaded_d;
            cfg_busy_q   <= cfg_busy_d;
            rom_addr_q   <= rom_addr_d;
            c_we_q       <= c_we_d;
            c_addr_q     <= c_addr_d;
            wr_q         <= wr_d;
            samp_acc_q   <= samp_acc_d;
            ce_q         <= ce_d;
            mult_sel_q   <= mult_sel_d;
            out_valid_q  <= out_valid_d;
            run_busy_q   <= run_busy_d;
        end
    end

`ifdef IIR_SOS_CTRL_OVR_CNT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic        ovr_hit_s;

    // A strobe is an overrun when busy or when it loses to a same-cycle cfg_start.
    always_comb begin
        ovr_hit_s = bus.samp_stb && ((state_q != S_IDLE) || bus.cfg_start);
        if (ovr_hit_s && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_cnt_d = ovr_cnt_q + 16'd1;
        end else begin
            ovr_cnt_d = ovr_cnt_q;
        end
    end

    // Saturating overrun counter register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ovr_cnt_q <= 16'h0000;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign bus.ovr_cnt = ovr_cnt_q;
`else
    assign bus.ovr_cnt = 16'h0000;
`endif

    assign bus.cfg_busy   = cfg_busy_q;
    assign bus.cfg_loaded = cfg_loaded_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.c_we       = c_we_q;
    assign bus.c_addr     = c_addr_q;
    // ROM data only arrives in the write cycle itself, so it is gated by a
    // registered write flag instead of being re-registered.
    assign bus.c_in       = wr_q ? bus.rom_data : {COEFF_W{1'b0}};
    assign bus.samp_acc   = samp_acc_q;
    assign bus.ce         = ce_q;
    assign bus.mult_sel   = mult_sel_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.run_busy   = run_busy_q;
endmodule

// File: tb/tb_iir_sos_ctrl.sv
// Self-checking bench for iir_sos_ctrl (N_SECT=4). Expected coefficient
// writes and out_valid cycles are queued when stimulus is driven and popped
// when the DUT produces them.
module tb_iir_sos_ctrl;
    localparam int N   = 4;
    localparam int AW  = 2;
    localparam int CW  = 16;
    localparam int SEQ = 3 * N + 1;

    typedef struct packed {
        logic [N-1:0]  we;
        logic [1:0]    addr;
        logic [CW-1:0] din;
    } wr_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   ovr_exp = 0;
    wr_t  wr_q[$];
    int   ov_q[$];

    iir_sos_ctrl_if #(.N_SECT(N), .SECT_AW(AW), .COEFF_W(CW)) ifc ();

    iir_sos_ctrl #(.N_SECT(N), .SECT_AW(AW), .COEFF_W(CW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Coefficient ROM: word j = sec*3 + idx holds 16'h1000 + j, one-cycle latency.
    always @(posedge clk)
        ifc.rom_data <= 16'h1000 + 16'(ifc.rom_addr[3:2]) * 16'd3 + 16'(ifc.rom_addr[1:0]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        ifc.cfg_start = 1'b0;
        ifc.samp_stb = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({ifc.ce, ifc.c_we} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ce_we: got %b expected 00000000", {ifc.ce, ifc.c_we});
        end
        n_tests++;
        if ({ifc.rom_addr, ifc.c_addr, ifc.c_in} !== 22'h0) begin
            n_fail++; $display("FAIL reset_bus: got %h expected 0", {ifc.rom_addr, ifc.c_addr, ifc.c_in});
        end
        n_tests++;
        if ({ifc.cfg_busy, ifc.cfg_loaded, ifc.samp_acc, ifc.mult_sel, ifc.out_valid, ifc.run_busy} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                {ifc.cfg_busy, ifc.cfg_loaded, ifc.samp_acc, ifc.mult_sel, ifc.out_valid, ifc.run_busy});
        end
        n_tests++;
        if (ifc.ovr_cnt !== 16'h0000) begin
            n_fail++; $display("FAIL reset_ovr: got %h expected 0000", ifc.ovr_cnt);
        end
        ovr_exp = 0;
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_stb_before_load();
        ifc.samp_stb = 1'b1;
        tick();
        ifc.samp_stb = 1'b0;
        for (int r = 1; r <= 15; r++) begin
            n_tests++;
            if ({ifc.samp_acc, ifc.ce, ifc.run_busy, ifc.out_valid} !== 7'b0) begin
                n_fail++; $display("FAIL unloaded_stb r=%0d: got %b expected 0000000", r,
                    {ifc.samp_acc, ifc.ce, ifc.run_busy, ifc.out_valid});
            end
            tick();
        end
        n_tests++;
        if (ifc.ovr_cnt !== 16'(ovr_exp)) begin
            n_fail++; $display("FAIL unloaded_ovr: got %h expected %h", ifc.ovr_cnt, 16'(ovr_exp));
        end
    endtask

    task automatic test_cfg_load(input bit with_stb);
        int        c0;
        int        j;
        wr_t       w;
        wr_t       got;
        logic [N-1:0] one;
        logic [3:0]   addr_exp;
        one = 4'b0001;
        c0 = cyc;
        ifc.cfg_start = 1'b1;
        ifc.samp_stb = with_stb;
        for (int k = 0; k < 3 * N; k++) begin
            w.we = one << (k / 3);
            w.addr = 2'(k % 3);
            w.din = 16'h1000 + 16'(k);
            wr_q.push_back(w);
        end
`ifdef IIR_SOS_CTRL_OVR_CNT_EN
        if (with_stb) ovr_exp++;
`endif
        tick();
        ifc.cfg_start = 1'b0;
        ifc.samp_stb = 1'b0;
        if (with_stb) begin
            n_tests++;
            if (ifc.samp_acc !== 1'b0) begin
                n_fail++; $display("FAIL cfg_stb_acc: got %b expected 0", ifc.samp_acc);
            end
            n_tests++;
            if (ifc.ovr_cnt !== 16'(ovr_exp)) begin
                n_fail++; $display("FAIL cfg_stb_ovr: got %h expected %h", ifc.ovr_cnt, 16'(ovr_exp));
            end
        end
        for (int r = 1; r <= 16; r++) begin
            j = r - 1;
            addr_exp = (r <= 3 * N) ? {2'(j / 3), 2'(j % 3)} : 4'h0;
            n_tests++;
            if (ifc.cfg_busy !== (r <= SEQ)) begin
                n_fail++; $display("FAIL cfg_busy r=%0d: got %b expected %b", r, ifc.cfg_busy, (r <= SEQ));
            end
            n_tests++;
            if (ifc.cfg_loaded !== (r >= SEQ + 1)) begin
                n_fail++; $display("FAIL cfg_loaded r=%0d: got %b expected %b", r, ifc.cfg_loaded, (r >= SEQ + 1));
            end
            n_tests++;
            if (ifc.rom_addr !== addr_exp) begin
                n_fail++; $display("FAIL rom_addr r=%0d: got %h expected %h", r, ifc.rom_addr, addr_exp);
            end
            n_tests++;
            if (ifc.ce !== 4'b0000) begin
                n_fail++; $display("FAIL cfg_ce r=%0d: got %b expected 0000", r, ifc.ce);
            end
            if (ifc.c_we !== 4'b0000) begin
                got = '{we: ifc.c_we, addr: ifc.c_addr, din: ifc.c_in};
                n_tests++;
                if (wr_q.size() == 0) begin
                    n_fail++; $display("FAIL cfg_write_extra r=%0d: got %h expected none", r, got);
                end else begin
                    w = wr_q.pop_front();
                    if (got !== w) begin
                        n_fail++; $display("FAIL cfg_write r=%0d: got we=%b a=%0d d=%h expected we=%b a=%0d d=%h",
                            r, got.we, got.addr, got.din, w.we, w.addr, w.din);
                    end
                end
            end
            tick();
        end
        n_tests++;
        if (wr_q.size() != 0) begin
            n_fail++; $display("FAIL cfg_write_missing: got %0d left expected 0", wr_q.size());
        end
        wr_q.delete();
    endtask

    task automatic test_single_sample();
        int c0;
        int k;
        int ph;
        int exp_c;
        logic [N-1:0] one;
        logic [N-1:0] ce_exp;
        logic ms_exp;
        one = 4'b0001;
        c0 = cyc;
        ifc.samp_stb = 1'b1;
        ov_q.push_back(c0 + SEQ);
        tick();
        ifc.samp_stb = 1'b0;
        for (int r = 1; r <= 16; r++) begin
            k = (r - 1) / 3;
            ph = (r - 1) % 3;
            ce_exp = (r <= 3 * N && ph < 2) ? (one << k) : 4'b0000;
            ms_exp = (r <= 3 * N && ph == 1);
            n_tests++;
            if ({ifc.ce, ifc.mult_sel} !== {ce_exp, ms_exp}) begin
                n_fail++; $display("FAIL run_ce_ms r=%0d: got %b/%b expected %b/%b", r, ifc.ce, ifc.mult_sel, ce_exp, ms_exp);
            end
            n_tests++;
            if ({ifc.samp_acc, ifc.run_busy} !== {(r == 1), (r <= 3 * N)}) begin
                n_fail++; $display("FAIL run_acc_busy r=%0d: got %b%b expected %b%b", r, ifc.samp_acc, ifc.run_busy,
                    (r == 1), (r <= 3 * N));
            end
            n_tests++;
            if (ifc.out_valid !== (r == SEQ)) begin
                n_fail++; $display("FAIL run_out_valid r=%0d: got %b expected %b", r, ifc.out_valid, (r == SEQ));
            end
            if (ifc.out_valid === 1'b1 && ov_q.size() != 0) begin
                exp_c = ov_q.pop_front();
                n_tests++;
                if (cyc !== exp_c) begin
                    n_fail++; $display("FAIL run_ov_cycle: got %0d expected %0d", cyc, exp_c);
                end
            end
            tick();
        end
        n_tests++;
        if (ov_q.size() != 0) begin
            n_fail++; $display("FAIL run_ov_missing: got %0d pending expected 0", ov_q.size());
        end
        ov_q.delete();
    endtask

    task automatic test_stream(input int period, input int n_stb, input int span);
        int next_free;
        int exp_c;
        int n_ov;
        int n_acc_exp;
        next_free = cyc;
        n_ov = 0;
        n_acc_exp = 0;
        for (int i = 0; i < span; i++) begin
            ifc.samp_stb = (i % period == 0) && (i < period * n_stb);
            if (ifc.samp_stb) begin
                if (cyc >= next_free) begin
                    ov_q.push_back(cyc + SEQ);
                    next_free = cyc + SEQ;
                    n_acc_exp++;
                end else begin
`ifdef IIR_SOS_CTRL_OVR_CNT_EN
                    ovr_exp++;
`endif
                end
            end
            if (ifc.out_valid === 1'b1) begin
                n_ov++;
                n_tests++;
                if (ov_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_ov_extra p=%0d: got pulse at %0d expected none", period, cyc);
                end else begin
                    exp_c = ov_q.pop_front();
                    if (cyc !== exp_c) begin
                        n_fail++; $display("FAIL stream_ov_cycle p=%0d: got %0d expected %0d", period, cyc, exp_c);
                    end
                end
            end
            tick();
        end
        ifc.samp_stb = 1'b0;
        n_tests++;
        if (n_ov !== n_acc_exp) begin
            n_fail++; $display("FAIL stream_ov_count p=%0d: got %0d expected %0d", period, n_ov, n_acc_exp);
        end
        n_tests++;
        if (ifc.ovr_cnt !== 16'(ovr_exp)) begin
            n_fail++; $display("FAIL stream_ovr p=%0d: got %h expected %h", period, ifc.ovr_cnt, 16'(ovr_exp));
        end
        ov_q.delete();
    endtask

    task automatic test_back_to_back();
        test_stream(SEQ, 10, SEQ * 10 + 15);
    endtask

    task automatic test_overrun();
        test_stream(6, 8, 60);
    endtask

    task automatic test_reset_mid_run();
        ifc.samp_stb = 1'b1;
        tick();
        ifc.samp_stb = 1'b0;
        repeat (7) tick();
        n_tests++;
        if ({ifc.ce, ifc.mult_sel} !== 5'b0100_1) begin
            n_fail++; $display("FAIL mid_run_pre: got %b/%b expected 0100/1", ifc.ce, ifc.mult_sel);
        end
        nrst = 1'b0;
        tick();
        n_tests++;
        if ({ifc.ce, ifc.c_we, ifc.mult_sel, ifc.samp_acc, ifc.out_valid, ifc.run_busy, ifc.cfg_busy, ifc.cfg_loaded} !== 14'b0) begin
            n_fail++; $display("FAIL mid_run_reset: got %b expected all zero",
                {ifc.ce, ifc.c_we, ifc.mult_sel, ifc.samp_acc, ifc.out_valid, ifc.run_busy, ifc.cfg_busy, ifc.cfg_loaded});
        end
        n_tests++;
        if ({ifc.rom_addr, ifc.c_addr, ifc.c_in, ifc.ovr_cnt} !== 38'h0) begin
            n_fail++; $display("FAIL mid_run_reset_bus: got %h expected 0", {ifc.rom_addr, ifc.c_addr, ifc.c_in, ifc.ovr_cnt});
        end
        ovr_exp = 0;
        nrst = 1'b1;
        ifc.samp_stb = 1'b1;
        tick();
        ifc.samp_stb = 1'b0;
        for (int r = 1; r <= 15; r++) begin
            n_tests++;
            if ({ifc.samp_acc, ifc.ce, ifc.run_busy, ifc.out_valid} !== 7'b0) begin
                n_fail++; $display("FAIL after_reset_stb r=%0d: got %b expected 0000000", r,
                    {ifc.samp_acc, ifc.ce, ifc.run_busy, ifc.out_valid});
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.cfg_start = 1'b0;
        ifc.samp_stb = 1'b0;
        test_reset();
        test_stb_before_load();
        test_cfg_load(1'b0);
        test_single_sample();
        test_back_to_back();
        test_overrun();
        test_reset_mid_run();
        test_cfg_load(1'b1);
        test_single_sample();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
